// File: rtl/climate_source_selector_if.sv
// Sample, threshold and actuator signals between the threshold controller, the
// source selector and the actuator drivers.
interface climate_source_selector_if;
    logic               sample_valid;
    logic        [15:0] light_level;
    logic signed [7:0]  indoor_temp;

    logic        [15:0] solar_th;
    logic signed [7:0]  solar_cooldown_th;
    logic signed [7:0]  solar_heatup_th;
    logic signed [7:0]  ambient_cooldown_th;
    logic signed [7:0]  ambient_heatup_th;
    logic signed [7:0]  geothermal_cooldown_th;
    logic signed [7:0]  geothermal_heatup_th;

    logic               solar_en;
    logic               ambient_en;
    logic               geo_en;
    logic               mode_heat;
    logic               mode_cool;
    logic        [1:0]  active_source;

    modport master (
        output sample_valid, light_level, indoor_temp,
        output solar_th, solar_cooldown_th, solar_heatup_th,
        output ambient_cooldown_th, ambient_heatup_th,
        output geothermal_cooldown_th, geothermal_heatup_th,
        input  solar_en, ambient_en, geo_en, mode_heat, mode_cool, active_source
    );

    modport slave (
        input  sample_valid, light_level, indoor_temp,
        input  solar_th, solar_cooldown_th, solar_heatup_th,
        input  ambient_cooldown_th, ambient_heatup_th,
        input  geothermal_cooldown_th, geothermal_heatup_th,
        output solar_en, ambient_en, geo_en, mode_heat, mode_cool, active_source
    );
endinterface

// File: rtl/climate_source_selector.sv
// Chooses a thermal source (solar > ambient > geothermal) and heat/cool direction from
// sampled light and temperature, with hysteresis, minimum dwell and a dead time between sources.
module climate_source_selector #(
    parameter int unsigned HYST        = 1,
    parameter int unsigned MIN_DWELL   = 4,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input logic                      clk,
    input logic                      rst,
    climate_source_selector_if.slave bus
);

    typedef enum logic [2:0] {StOff, StSolar, StAmbient, StGeo, StDead} state_e;

    localparam logic [1:0] SrcNone    = 2'd0;
    localparam logic [1:0] SrcSolar   = 2'd1;
    localparam logic [1:0] SrcAmbient = 2'd2;
    localparam logic [1:0] SrcGeo     = 2'd3;

    localparam logic signed [8:0] HystX    = 9'(HYST);
    localparam logic        [3:0] MinDwell = 4'(MIN_DWELL);
    localparam logic        [7:0] DeadLast = 8'(DEAD_CYCLES - 1);

    state_e            state_q, state_d;
    logic              dir_cool_q, dir_cool_d;
    logic        [3:0] dwell_q, dwell_d;
    logic        [7:0] dead_cnt_q, dead_cnt_d;
    logic        [1:0] target_src_q, target_src_d;
    logic              target_cool_q, target_cool_d;
    logic              eval_pending_q, eval_pending_d;
    logic       [15:0] light_q;
    logic signed [7:0] temp_q;

    logic              solar_en_q, solar_en_d;
    logic              ambient_en_q, ambient_en_d;
    logic              geo_en_q, geo_en_d;
    logic              mode_heat_q, mode_heat_d;
    logic              mode_cool_q, mode_cool_d;
    logic        [1:0] active_q, active_d;

    // Temperatures and thresholds widened so threshold +/- HYST cannot wrap.
    logic signed [8:0] temp_x;
    logic signed [8:0] sol_cool_x, sol_heat_x;
    logic signed [8:0] amb_cool_x, amb_heat_x;
    logic signed [8:0] geo_cool_x, geo_heat_x;

    assign temp_x     = {temp_q[7], temp_q};
    assign sol_cool_x = {bus.solar_cooldown_th[7], bus.solar_cooldown_th};
    assign sol_heat_x = {bus.solar_heatup_th[7], bus.solar_heatup_th};
    assign amb_cool_x = {bus.ambient_cooldown_th[7], bus.ambient_cooldown_th};
    assign amb_heat_x = {bus.ambient_heatup_th[7], bus.ambient_heatup_th};
    assign geo_cool_x = {bus.geothermal_cooldown_th[7], bus.geothermal_cooldown_th};
    assign geo_heat_x = {bus.geothermal_heatup_th[7], bus.geothermal_heatup_th};

    logic       solar_ok;
    logic [3:1] cool_req, heat_req;

    assign solar_ok    = light_q >= bus.solar_th;
    assign cool_req[1] = solar_ok && (temp_x >= sol_cool_x);
    assign heat_req[1] = solar_ok && (temp_x <= sol_heat_x);
    assign cool_req[2] = temp_x >= amb_cool_x;
    assign heat_req[2] = temp_x <= amb_heat_x;
    assign cool_req[3] = temp_x >= geo_cool_x;
    assign heat_req[3] = temp_x <= geo_heat_x;

    logic [1:0] cand_src;
    logic       cand_cool;

    always_comb begin
        cand_src  = SrcNone;
        cand_cool = 1'b0;
        if (cool_req[1] || heat_req[1]) begin
            cand_src  = SrcSolar;
            cand_cool = cool_req[1];
        end else if (cool_req[2] || heat_req[2]) begin
            cand_src  = SrcAmbient;
            cand_cool = cool_req[2];
        end else if (cool_req[3] || heat_req[3]) begin
            cand_src  = SrcGeo;
            cand_cool = cool_req[3];
        end
    end

    // Thresholds of the source currently engaged, for the hysteresis exit test.
    logic        [1:0] cur_src;
    logic signed [8:0] cur_cool_x, cur_heat_x;
    logic              exit_met;
    logic        [3:0] dwell_inc;

    always_comb begin
        cur_src    = SrcNone;
        cur_cool_x = sol_cool_x;
        cur_heat_x = sol_heat_x;
        case (state_q)
            StSolar: cur_src = SrcSolar;
            StAmbient: begin
                cur_src    = SrcAmbient;
                cur_cool_x = amb_cool_x;
                cur_heat_x = amb_heat_x;
            end
            StGeo: begin
                cur_src    = SrcGeo;
                cur_cool_x = geo_cool_x;
                cur_heat_x = geo_heat_x;
            end
            default: ;
        endcase
    end

    assign exit_met  = dir_cool_q ? (temp_x < (cur_cool_x - HystX))
                                  : (temp_x > (cur_heat_x + HystX));
    assign dwell_inc = (dwell_q >= MinDwell) ? MinDwell : dwell_q + 4'd1;

    function automatic state_e src_to_state(logic [1:0] src);
        case (src)
            SrcSolar:   return StSolar;
            SrcAmbient: return StAmbient;
            SrcGeo:     return StGeo;
            default:    return StOff;
        endcase
    endfunction

    logic go_dead, go_off;

    always_comb begin
        state_d        = state_q;
        dir_cool_d     = dir_cool_q;
        dwell_d        = dwell_q;
        dead_cnt_d     = dead_cnt_q;
        target_src_d   = target_src_q;
        target_cool_d  = target_cool_q;
        eval_pending_d = eval_pending_q;
        go_dead        = 1'b0;
        go_off         = 1'b0;

        case (state_q)
            StOff: begin
                if (eval_pending_q) begin
                    eval_pending_d = 1'b0;
                    if (cand_src != SrcNone) begin
                        state_d    = src_to_state(cand_src);
                        dir_cool_d = cand_cool;
                        dwell_d    = 4'd0;
                    end
                end
            end
            StSolar, StAmbient, StGeo: begin
                if (eval_pending_q) begin
                    eval_pending_d = 1'b0;
                    dwell_d        = dwell_inc;
                    if (state_q == StSolar && !solar_ok) begin
                        // Losing light is not voluntary: ignore dwell.
                        go_dead = cand_src != SrcNone;
                        go_off  = cand_src == SrcNone;
                    end else if (dwell_inc == MinDwell) begin
                        if (exit_met) begin
                            go_dead = cand_src != SrcNone;
                            go_off  = cand_src == SrcNone;
                        end else if (cand_src != SrcNone && cand_src < cur_src) begin
                            go_dead = 1'b1;
                        end
                    end
                end
            end
            StDead: begin
                if (dead_cnt_q == DeadLast) begin
                    state_d        = src_to_state(target_src_q);
                    dir_cool_d     = target_cool_q;
                    dwell_d        = 4'd0;
                    dead_cnt_d     = 8'd0;
                    eval_pending_d = 1'b0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 8'd1;
                end
            end
            default: state_d = StOff;
        endcase

        if (go_off) begin
            state_d = StOff;
            dwell_d = 4'd0;
        end
        if (go_dead) begin
            state_d       = StDead;
            target_src_d  = cand_src;
            target_cool_d = cand_cool;
            dead_cnt_d    = 8'd0;
        end
        if (bus.sample_valid) begin
            eval_pending_d = 1'b1;
        end
    end

    always_comb begin
        solar_en_d   = 1'b0;
        ambient_en_d = 1'b0;
        geo_en_d     = 1'b0;
        active_d     = SrcNone;
        case (state_d)
            StSolar: begin
                solar_en_d = 1'b1;
                active_d   = SrcSolar;
            end
            StAmbient: begin
                ambient_en_d = 1'b1;
                active_d     = SrcAmbient;
            end
            StGeo: begin
                geo_en_d = 1'b1;
                active_d = SrcGeo;
            end
            default: ;
        endcase
        mode_cool_d = (active_d != SrcNone) && dir_cool_d;
        mode_heat_d = (active_d != SrcNone) && !dir_cool_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StOff;
            dir_cool_q     <= 1'b0;
            dwell_q        <= 4'd0;
            dead_cnt_q     <= 8'd0;
            target_src_q   <= SrcNone;
            target_cool_q  <= 1'b0;
            eval_pending_q <= 1'b0;
            light_q        <= 16'd0;
            temp_q         <= 8'sd0;
            solar_en_q     <= 1'b0;
            ambient_en_q   <= 1'b0;
            geo_en_q       <= 1'b0;
            mode_heat_q    <= 1'b0;
            mode_cool_q    <= 1'b0;
            active_q       <= SrcNone;
        end else begin
            state_q        <= state_d;
            dir_cool_q     <= dir_cool_d;
            dwell_q        <= dwell_d;
            dead_cnt_q     <= dead_cnt_d;
            target_src_q   <= target_src_d;
            target_cool_q  <= target_cool_d;
            eval_pending_q <= eval_pending_d;
            if (bus.sample_valid) begin
                light_q <= bus.light_level;
                temp_q  <= bus.indoor_temp;
            end
            solar_en_q     <= solar_en_d;
            ambient_en_q   <= ambient_en_d;
            geo_en_q       <= geo_en_d;
            mode_heat_q    <= mode_heat_d;
            mode_cool_q    <= mode_cool_d;
            active_q       <= active_d;
        end
    end

    assign bus.solar_en      = solar_en_q;
    assign bus.ambient_en    = ambient_en_q;
    assign bus.geo_en        = geo_en_q;
    assign bus.mode_heat     = mode_heat_q;
    assign bus.mode_cool     = mode_cool_q;
    assign bus.active_source = active_q;

endmodule

// File: tb/tb_climate_source_selector.sv
// Bench for climate_source_selector: directed scenarios plus randomized traffic
// against an integer reference model of the selection rules.
module tb_climate_source_selector;

    localparam int unsigned HYST        = 1;
    localparam int unsigned MIN_DWELL   = 4;
    localparam int unsigned DEAD_CYCLES = 16;

    // {solar_en, ambient_en, geo_en, mode_heat, mode_cool, active_source}
    localparam logic [6:0] OutOff       = 7'b0000000;
    localparam logic [6:0] OutSolarCool = 7'b1000101;
    localparam logic [6:0] OutSolarHeat = 7'b1001001;
    localparam logic [6:0] OutAmbCool   = 7'b0100110;
    localparam logic [6:0] OutGeoHeat   = 7'b0011011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    climate_source_selector_if bus ();

    climate_source_selector #(
        .HYST        (HYST),
        .MIN_DWELL   (MIN_DWELL),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_src 0 none, 1 solar, 2 ambient, 3 geothermal.
    int m_src, m_dwell, m_dead_left, m_tgt, m_light, m_temp;
    bit m_cool, m_dead, m_tgt_cool, m_pending;

    function automatic void model_reset();
        m_src = 0; m_dwell = 0; m_dead_left = 0; m_tgt = 0; m_light = 0; m_temp = 0;
        m_cool = 0; m_dead = 0; m_tgt_cool = 0; m_pending = 0;
    endfunction

    function automatic void model_edge();
        int  cool_th[4];
        int  heat_th[4];
        int  cand = 0;
        bit  cand_cool = 0;
        bit  ok;
        bit  leave = 0;
        bit  exit_met;
        cool_th[0] = 0; heat_th[0] = 0;
        cool_th[1] = $signed(bus.solar_cooldown_th);
        heat_th[1] = $signed(bus.solar_heatup_th);
        cool_th[2] = $signed(bus.ambient_cooldown_th);
        heat_th[2] = $signed(bus.ambient_heatup_th);
        cool_th[3] = $signed(bus.geothermal_cooldown_th);
        heat_th[3] = $signed(bus.geothermal_heatup_th);
        ok = m_light >= int'(bus.solar_th);
        for (int s = 1; s <= 3; s++) begin
            if (cand == 0 && !(s == 1 && !ok)) begin
                if (m_temp >= cool_th[s]) begin
                    cand = s; cand_cool = 1;
                end else if (m_temp <= heat_th[s]) begin
                    cand = s; cand_cool = 0;
                end
            end
        end
        if (m_dead) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_dead = 0; m_src = m_tgt; m_cool = m_tgt_cool; m_dwell = 0; m_pending = 0;
            end
        end else if (m_pending) begin
            m_pending = 0;
            if (m_src == 0) begin
                if (cand != 0) begin
                    m_src = cand; m_cool = cand_cool; m_dwell = 0;
                end
            end else begin
                m_dwell = (m_dwell + 1 > int'(MIN_DWELL)) ? int'(MIN_DWELL) : m_dwell + 1;
                exit_met = m_cool ? (m_temp < cool_th[m_src] - int'(HYST))
                                  : (m_temp > heat_th[m_src] + int'(HYST));
                if (m_src == 1 && !ok) leave = 1;
                else if (m_dwell == int'(MIN_DWELL) && (exit_met || (cand != 0 && cand < m_src)))
                    leave = 1;
                if (leave) begin
                    if (cand == 0) begin
                        m_src = 0; m_dwell = 0;
                    end else begin
                        m_dead = 1; m_dead_left = DEAD_CYCLES; m_tgt = cand; m_tgt_cool = cand_cool;
                    end
                end
            end
        end
        if (bus.sample_valid) begin
            m_light = int'(bus.light_level);
            m_temp  = $signed(bus.indoor_temp);
            m_pending = 1;
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [6:0] v = '0;
        if (!m_dead && m_src != 0) begin
            v[6]   = m_src == 1;
            v[5]   = m_src == 2;
            v[4]   = m_src == 3;
            v[3]   = !m_cool;
            v[2]   = m_cool;
            v[1:0] = 2'(m_src);
        end
        return v;
    endfunction

    function automatic logic [6:0] got_vec();
        return {bus.solar_en, bus.ambient_en, bus.geo_en, bus.mode_heat, bus.mode_cool,
                bus.active_source};
    endfunction

    task automatic step();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int light, input int temp);
        bus.sample_valid = 1'b1;
        bus.light_level  = 16'(light);
        bus.indoor_temp  = 8'(temp);
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic set_defaults();
        bus.solar_th               = 16'd2550;
        bus.solar_cooldown_th      = 8'sd35;
        bus.solar_heatup_th        = 8'sd16;
        bus.ambient_cooldown_th    = 8'sd35;
        bus.ambient_heatup_th      = 8'sd16;
        bus.geothermal_cooldown_th = 8'sd35;
        bus.geothermal_heatup_th   = 8'sd16;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.sample_valid = 1'b1;
        bus.light_level  = 16'($urandom);
        bus.indoor_temp  = 8'($urandom);
        bus.solar_th     = 16'($urandom);
        step();
        step();
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", got_vec(), OutOff);
        end
        bus.sample_valid = 1'b0;
        set_defaults();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_tests++;
            if (got_vec() !== OutOff) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, got_vec(), OutOff);
            end
        end
    endtask

    task automatic test_solar_cool();
        send_sample(3000, 40);
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL solar_cool_capture_edge: got %b expected %b", got_vec(), OutOff);
        end
        step();
        n_tests++;
        if (got_vec() !== OutSolarCool) begin
            n_fail++;
            $display("FAIL solar_cool_eval_edge: got %b expected %b", got_vec(), OutSolarCool);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) begin
            send_sample(3000, 34);
            step();
            n_tests++;
            if (got_vec() !== OutSolarCool) begin
                n_fail++;
                $display("FAIL hyst_hold eval %0d: got %b expected %b", i, got_vec(), OutSolarCool);
            end
        end
        send_sample(3000, 33);
        step();
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL hyst_exit_off: got %b expected %b", got_vec(), OutOff);
        end
    endtask

    task automatic test_solar_loss();
        send_sample(3000, 40);
        step();
        send_sample(100, 40);
        step();
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL solar_loss_drop: got %b expected %b", got_vec(), OutOff);
        end
        repeat (DEAD_CYCLES - 1) step();
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL solar_loss_dead_end: got %b expected %b", got_vec(), OutOff);
        end
        step();
        n_tests++;
        if (got_vec() !== OutAmbCool) begin
            n_fail++;
            $display("FAIL solar_loss_ambient: got %b expected %b", got_vec(), OutAmbCool);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        set_defaults();
        // Keep ambient quiet so the heat request lands on geothermal.
        bus.ambient_cooldown_th = 8'sd100;
        bus.ambient_heatup_th   = 8'sd0;
        send_sample(0, 10);
        step();
        n_tests++;
        if (got_vec() !== OutGeoHeat) begin
            n_fail++;
            $display("FAIL preempt_geo_entry: got %b expected %b", got_vec(), OutGeoHeat);
        end
        for (int i = 0; i < 3; i++) begin
            send_sample(3000, 10);
            step();
            n_tests++;
            if (got_vec() !== OutGeoHeat) begin
                n_fail++;
                $display("FAIL preempt_geo_hold eval %0d: got %b expected %b", i, got_vec(),
                         OutGeoHeat);
            end
        end
        send_sample(3000, 10);
        step();
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL preempt_dead_entry: got %b expected %b", got_vec(), OutOff);
        end
        repeat (DEAD_CYCLES) step();
        n_tests++;
        if (got_vec() !== OutSolarHeat) begin
            n_fail++;
            $display("FAIL preempt_solar_heat: got %b expected %b", got_vec(), OutSolarHeat);
        end
    endtask

    task automatic test_reset_mid();
        // Currently in SOLAR heat: an asynchronous reset must clear outputs at once.
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL reset_mid_source: got %b expected %b", got_vec(), OutOff);
        end
        #1 rst = 1'b0;
        set_defaults();
        send_sample(3000, 40);
        step();
        send_sample(100, 40);
        step();
        repeat (5) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL reset_mid_dead: got %b expected %b", got_vec(), OutOff);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            n_tests++;
            if (got_vec() !== OutOff) begin
                n_fail++;
                $display("FAIL reset_mid_dead_idle cycle %0d: got %b expected %b", i, got_vec(),
                         OutOff);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.sample_valid = 1'b1;
        bus.light_level  = 16'd3000;
        bus.indoor_temp  = 8'sd20;
        step();
        bus.indoor_temp  = 8'sd40;
        step();
        bus.sample_valid = 1'b0;
        n_tests++;
        if (got_vec() !== OutOff) begin
            n_fail++;
            $display("FAIL b2b_first_eval: got %b expected %b", got_vec(), OutOff);
        end
        step();
        n_tests++;
        if (got_vec() !== OutSolarCool) begin
            n_fail++;
            $display("FAIL b2b_second_eval: got %b expected %b", got_vec(), OutSolarCool);
        end
    endtask

    task automatic randomize_thresholds();
        bus.solar_th               = 16'($urandom_range(4000, 1000));
        bus.solar_cooldown_th      = 8'(int'($urandom_range(50, 20)));
        bus.solar_heatup_th        = 8'(int'($urandom_range(40, 0)) - 10);
        bus.ambient_cooldown_th    = 8'(int'($urandom_range(50, 20)));
        bus.ambient_heatup_th      = 8'(int'($urandom_range(40, 0)) - 10);
        bus.geothermal_cooldown_th = 8'(int'($urandom_range(50, 20)));
        bus.geothermal_heatup_th   = 8'(int'($urandom_range(40, 0)) - 10);
    endtask

    task automatic test_random();
        int errs_before;
        do_reset();
        randomize_thresholds();
        errs_before = n_fail;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(59, 0) == 0) randomize_thresholds();
            bus.sample_valid = $urandom_range(2, 0) == 0;
            bus.light_level  = 16'($urandom_range(5000, 0));
            bus.indoor_temp  = 8'(int'($urandom_range(80, 0)) - 20);
            step();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                if (n_fail - errs_before <= 10)
                    $display("FAIL random cycle %0d: got %b expected %b", i, got_vec(), exp_vec());
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.sample_valid = 1'b0;
        bus.light_level  = '0;
        bus.indoor_temp  = '0;
        set_defaults();
        test_reset();
        test_solar_cool();
        test_hysteresis();
        test_solar_loss();
        test_preempt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
